bus_target: RTL
===============

// Module: bus_target
// PURPOSE
//  External-bus responder: the far end of the CPU's multiplexed 20-bit address / 16-bit data pin bus.
//  Synchronises ALE/OE/WE strobes, latches the address, and turns each strobe into one
//  req/ack access on a local memory/IO port. Drives read data back onto the AD pins.
//  Sits in the memory/peripheral FPGA, or in simulation as the CPU's bus model.
// PARAMETERS
//  SYNC_STAGES  2    flops per strobe/data synchroniser (>=2)
//  TIMEOUT      255  max cycles to wait for mem_ack (used only with BUS_TARGET_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  ad_in      in   16  AD pins as read from the bus (address low word or write data)
//  ad_out     out  16  read data to drive onto the AD pins
//  ad_oe      out  1   1 = drive ad_out onto the pins
//  adr_hi     in   4   address bits [19:16]
//  pio        in   1   1 = IO space, 0 = memory space; latched with the address
//  ale_n      in   1   address latch enable, active-low
//  oe_n       in   1   read strobe, active-low
//  we_n       in   1   write strobe, active-low
//  mem_req    out  1   local access request
//  mem_ack    in   1   local access done, one-cycle pulse
//  mem_rw     out  1   1 = read, 0 = write
//  mem_io     out  1   latched pio
//  mem_adr    out  20  latched {adr_hi, ad}
//  mem_wdata  out  16  captured write data
//  mem_rdata  in   16  read data, valid in the mem_ack cycle
//  err        out  1   sticky protocol error; cleared only by rst
// BEHAVIOUR
//  - Reset: every output 0 and state IDLE. Any outstanding req is dropped without waiting for ack.
//  - Sync: ale_n, oe_n, we_n, ad_in, adr_hi and pio pass through the same SYNC_STAGES pipeline,
//    so the samples stay aligned. All decisions below use the synced values (suffix _s).
//  - Edges: an edge is detected as a _s change between consecutive cycles.
//  - States: IDLE, ADDR, ARMED, RD_REQ, RD_DRIVE, WR_CAP, WR_REQ, DRAIN.
//  - IDLE/ARMED -> ADDR when ale_n_s falls.
//  - ADDR -> ARMED when ale_n_s rises. On that cycle, mem_adr <= {adr_hi_s, ad_in_s} and mem_io <= pio_s.
//  - ARMED -> RD_REQ when oe_n_s falls. mem_req = 1 and mem_rw = 1 the next cycle.
//  - RD_REQ: hold mem_req until mem_ack. In the ack cycle, ad_out <= mem_rdata and ad_oe <= 1.
//    Then -> RD_DRIVE.
//  - RD_DRIVE: keep ad_oe = 1 until oe_n_s rises. Then ad_oe <= 0 and -> ARMED.
//  - ARMED -> WR_CAP when we_n_s falls.
//  - WR_CAP: on the we_n_s rise, mem_wdata <= ad_in_s from that same cycle. Then -> WR_REQ.
//  - WR_REQ: mem_req = 1 and mem_rw = 0 until mem_ack. Then -> ARMED.
//  - Latency: read is pin oe_n fall -> ad_oe high in SYNC_STAGES+2 cycles plus memory wait.
//  - Req/ack: mem_req rises the cycle after state entry and falls the cycle after mem_ack.
//    mem_adr, mem_rw and mem_wdata are stable while mem_req = 1.
//  - ad_oe is never 1 while ale_n_s = 0 or we_n_s = 0.
//  - Repeated strobes after one ALE reuse the latched address (no auto-increment).
//  - Simultaneous oe_n_s = 0 and we_n_s = 0: set err, ignore both, stay in ARMED.
//  - ale_n_s falls mid-access:
//    - ad_oe <= 0 immediately.
//    - If mem_req is outstanding -> DRAIN: hold req to ack, discard the result, then -> ADDR.
//    - If no req is outstanding -> ADDR directly.
//  - oe_n_s rises before mem_ack: finish the req, do not drive ad_oe, then -> ARMED.
//  - A strobe in IDLE (no address latched yet): set err and ignore it.
// CONFIGURATION
//  BUS_TARGET_TIMEOUT_EN defined:
//  - A counter runs while mem_req = 1.
//  - At TIMEOUT cycles without mem_ack: drop mem_req and set err.
//  - A read then drives 16'hFFFF until oe_n_s rises. A write is dropped.
//  - A late mem_ack after the timeout is ignored.
//  Not defined: no counter; wait for mem_ack indefinitely.
// STRUCTURE
//  - Shared package bus_pkg:
//    - state encodings
//    - ADDR_W = 20, DATA_W = 16
//    - RW_READ = 1, RW_WRITE = 0
//  - Sub-module bus_sync: SYNC_STAGES-deep flop chain, parameterised width, one instance for the
//    concatenated {ale_n, oe_n, we_n, pio, adr_hi, ad_in} vector.
// TESTING
//  1. ALE low with AD = 16'h1234, adr_hi = 4'hA, pio = 0, ALE high -> mem_adr = 20'hA1234, mem_io = 0.
//  2. Read: oe_n low, memory acks after 3 cycles with rdata = 16'hBEEF ->
//     ad_out = 16'hBEEF and ad_oe = 1 until SYNC_STAGES cycles after oe_n rises, then ad_oe = 0.
//  3. Write: we_n low with AD = 16'h55AA, we_n high -> one mem_req with mem_rw = 0 and
//     mem_wdata = 16'h55AA; exactly one request per strobe.
//  4. oe_n and we_n low together after ALE -> err = 1, no mem_req, ad_oe stays 0.
//  5. New ALE during RD_REQ, ack delayed 5 cycles -> ad_oe stays 0, mem_req held to ack,
//     next mem_adr = the new address.
//  6. rst pulse during WR_REQ -> all outputs 0 next cycle; with TIMEOUT_EN and no ack,
//     req drops after 255 cycles and err = 1.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the external-bus responder.
//   ADDR_W / DATA_W   pin bus address and data widths
//   RW_READ/RW_WRITE  mem_rw encodings
//   state_t           responder FSM states
//   SYNC_W            width of the combined {ale_n, oe_n, we_n, pio, adr_hi, ad} sample
package bus_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned HI_W   = ADDR_W - DATA_W;
    localparam int unsigned SYNC_W = 4 + HI_W + DATA_W;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ARMED,
        ST_RD_REQ,
        ST_RD_DRIVE,
        ST_WR_CAP,
        ST_WR_REQ,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/bus_sync.sv
// bus_sync: STAGES-deep flop chain for an asynchronous input vector. All bits
// travel through the same chain so samples taken together stay together.
//   clk    in  system clock
//   rst    in  synchronous reset, active-high (chain loads RST_VAL)
//   d      in  WIDTH-bit raw input
//   q      out WIDTH-bit synchronised output
module bus_sync #(
    parameter int unsigned          STAGES  = 2,
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_target.sv
// bus_target: far end of the CPU's multiplexed 20-bit address / 16-bit data bus.
// Synchronises the strobes, latches the address on ALE and turns each OE/WE
// strobe into one req/ack access on the local memory/IO port.
// Optional feature: define BUS_TARGET_TIMEOUT_EN to abandon a request after
// TIMEOUT cycles without mem_ack (sets err; reads then return 16'hFFFF).
//   clk, rst           clock, synchronous active-high reset
//   ad_in/ad_out/ad_oe AD pins in, read data out, output enable
//   adr_hi, pio        address bits [19:16], IO-space select
//   ale_n, oe_n, we_n  active-low bus strobes
//   mem_req/mem_ack    local access handshake (ack is a one-cycle pulse)
//   mem_rw, mem_io     1 = read / latched pio
//   mem_adr, mem_wdata latched address, captured write data
//   mem_rdata          read data, valid in the mem_ack cycle
//   err                sticky protocol error
module bus_target import bus_pkg::*; #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [HI_W-1:0]   adr_hi,
    input  logic              pio,
    input  logic              ale_n,
    input  logic              oe_n,
    input  logic              we_n,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              mem_rw,
    output logic              mem_io,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    if (SYNC_STAGES < 2 || TIMEOUT == 0) begin : g_param_check
        $error("bus_target: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
    end

    logic [SYNC_W-1:0] synced;
    logic              ale_n_s, oe_n_s, we_n_s, pio_s;
    logic [HI_W-1:0]   adr_hi_s;
    logic [DATA_W-1:0] ad_in_s;

    // Strobes reset to their inactive (high) level so no edge is seen out of reset.
    bus_sync #(
        .STAGES  (SYNC_STAGES),
        .WIDTH   (SYNC_W),
        .RST_VAL ({3'b111, {(SYNC_W-3){1'b0}}})
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({ale_n, oe_n, we_n, pio, adr_hi, ad_in}),
        .q   (synced)
    );

    assign {ale_n_s, oe_n_s, we_n_s, pio_s, adr_hi_s, ad_in_s} = synced;

    logic ale_p, oe_p, we_p;
    always_ff @(posedge clk) begin
        if (rst) begin
            ale_p <= 1'b1;
            oe_p  <= 1'b1;
            we_p  <= 1'b1;
        end else begin
            ale_p <= ale_n_s;
            oe_p  <= oe_n_s;
            we_p  <= we_n_s;
        end
    end

    logic ale_fall, ale_rise, oe_fall, oe_rise, we_fall, we_rise;
    assign ale_fall = ale_p & ~ale_n_s;
    assign ale_rise = ~ale_p & ale_n_s;
    assign oe_fall  = oe_p & ~oe_n_s;
    assign oe_rise  = ~oe_p & oe_n_s;
    assign we_fall  = we_p & ~we_n_s;
    assign we_rise  = ~we_p & we_n_s;

    state_t state, state_d;

    assign mem_req = (state == ST_RD_REQ) || (state == ST_WR_REQ) || (state == ST_DRAIN);

    logic timed_out;
`ifdef BUS_TARGET_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    always_ff @(posedge clk) begin
        if (rst || !mem_req) wait_cnt <= '0;
        else                 wait_cnt <= wait_cnt + 1'b1;
    end
    assign timed_out = mem_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    logic req_done;
    assign req_done = mem_ack | timed_out;

    logic ld_adr, ld_pend, use_pend, pend_clr, ld_wdata, ld_rdata;
    logic drive_set, drive_clr, err_set, abort_set, abort_clr, set_rd, set_wr;
    logic pend, abort, drive_q;
    logic [ADDR_W-1:0] pend_adr;
    logic              pend_io;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        ld_adr    = 1'b0;
        ld_pend   = 1'b0;
        use_pend  = 1'b0;
        pend_clr  = 1'b0;
        ld_wdata  = 1'b0;
        ld_rdata  = 1'b0;
        drive_set = 1'b0;
        drive_clr = 1'b0;
        err_set   = 1'b0;
        abort_set = 1'b0;
        abort_clr = 1'b0;
        set_rd    = 1'b0;
        set_wr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ale_fall)              state_d = ST_ADDR;
                else if (oe_fall || we_fall) err_set = 1'b1;
            end
            ST_ADDR: begin
                if (ale_rise) begin
                    ld_adr  = 1'b1;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (ale_fall) begin
                    state_d = ST_ADDR;
                end else if ((oe_fall || we_fall) && !oe_n_s && !we_n_s) begin
                    err_set = 1'b1;
                end else if (oe_fall) begin
                    set_rd    = 1'b1;
                    abort_clr = 1'b1;
                    state_d   = ST_RD_REQ;
                end else if (we_fall) begin
                    set_wr  = 1'b1;
                    state_d = ST_WR_CAP;
                end
            end
            ST_RD_REQ: begin
                if (ale_fall) begin
                    pend_clr = 1'b1;
                    state_d  = req_done ? ST_ADDR : ST_DRAIN;
                end else if (req_done) begin
                    // A read whose OE already went away completes silently.
                    if (abort || oe_n_s) begin
                        state_d = ST_ARMED;
                    end else begin
                        ld_rdata  = 1'b1;
                        drive_set = 1'b1;
                        state_d   = ST_RD_DRIVE;
                    end
                end else if (oe_rise) begin
                    abort_set = 1'b1;
                end
            end
            ST_RD_DRIVE: begin
                if (ale_fall) begin
                    drive_clr = 1'b1;
                    state_d   = ST_ADDR;
                end else if (oe_rise) begin
                    drive_clr = 1'b1;
                    state_d   = ST_ARMED;
                end
            end
            ST_WR_CAP: begin
                if (ale_fall) begin
                    state_d = ST_ADDR;
                end else if (we_rise) begin
                    ld_wdata = 1'b1;
                    state_d  = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (ale_fall) begin
                    pend_clr = 1'b1;
                    state_d  = req_done ? ST_ADDR : ST_DRAIN;
                end else if (req_done) begin
                    state_d = ST_ARMED;
                end
            end
            ST_DRAIN: begin
                // mem_adr must stay put while the abandoned request drains, so an
                // ALE cycle that completes meanwhile is parked in pend_adr and
                // applied once the ack arrives.
                if (req_done) begin
                    if (!ale_n_s) begin
                        state_d = ST_ADDR;
                    end else if (ale_rise) begin
                        ld_adr  = 1'b1;
                        state_d = ST_ARMED;
                    end else if (pend) begin
                        use_pend = 1'b1;
                        state_d  = ST_ARMED;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else if (ale_rise) begin
                    ld_pend = 1'b1;
                end else if (ale_fall) begin
                    pend_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_adr   <= '0;
            mem_io    <= 1'b0;
            mem_wdata <= '0;
            mem_rw    <= 1'b0;
            ad_out    <= '0;
            drive_q   <= 1'b0;
            err       <= 1'b0;
            abort     <= 1'b0;
            pend      <= 1'b0;
            pend_adr  <= '0;
            pend_io   <= 1'b0;
        end else begin
            if (ld_adr) begin
                mem_adr <= {adr_hi_s, ad_in_s};
                mem_io  <= pio_s;
            end else if (use_pend) begin
                mem_adr <= pend_adr;
                mem_io  <= pend_io;
            end
            if (ld_pend) begin
                pend_adr <= {adr_hi_s, ad_in_s};
                pend_io  <= pio_s;
                pend     <= 1'b1;
            end else if (pend_clr || use_pend) begin
                pend <= 1'b0;
            end
            if (ld_wdata) mem_wdata <= ad_in_s;
            if (ld_rdata) ad_out <= timed_out ? '1 : mem_rdata;
            if (set_rd)      mem_rw <= RW_READ;
            else if (set_wr) mem_rw <= RW_WRITE;
            if (drive_clr)      drive_q <= 1'b0;
            else if (drive_set) drive_q <= 1'b1;
            if (abort_clr)      abort <= 1'b0;
            else if (abort_set) abort <= 1'b1;
            err <= err | err_set | timed_out;
        end
    end

    // Never drive the pins while the CPU is driving them (ALE or WE phase).
    assign ad_oe = drive_q & ale_n_s & we_n_s;

endmodule
